fifo_rd_framer: RTL and testbench
=================================

# fifo_rd_framer

Read-side controller for the 1-bit async FIFO in the SerDes receive path. Runs in the FIFO read clock domain, issues read enables whenever the FIFO is non-empty, and collects the serial bit stream into FRAME_WIDTH-bit parallel frames. Completed frames go to the downstream deframer/consumer over a valid/ready handshake, with backpressure that stalls FIFO reads.

## Interface
- FRAME_WIDTH, 8: bits per frame (2..32).
- LSB_FIRST, 1: 1 = first bit read lands in o_Frame[0]; 0 = first bit lands in o_Frame[FRAME_WIDTH-1].
- CNT_WIDTH, 16: width of completed-frame counter.

Ports:
- i_Rclk  input  1  read-domain clock; all logic on rising edge.
- i_Rrst_n  input  1  reset; asynchronous, active-low.
- i_Enable  input  1  permits starting a new frame.
- i_Clr  input  1  synchronous abort: discard partial frame, go IDLE.
- i_Empty  input  1  FIFO empty flag (read domain).
- o_R_en  output  1  FIFO read enable (combinational from state/counters/i_Empty).
- i_Data_In  input  1  FIFO read data; valid the cycle after o_R_en was high.
- o_Frame  output  FRAME_WIDTH  assembled frame; stable while o_Valid.
- o_Valid  output  1  frame available.
- i_Ready  input  1  consumer accepts frame when o_Valid && i_Ready.
- o_Busy  output  1  high in FILL or PRESENT.
- o_Frame_Cnt  output  CNT_WIDTH  frames accepted since reset; wraps.

## Operation
- States: IDLE, FILL, PRESENT (registered).
- IDLE: i_Enable=1 -> FILL next cycle; counters cleared.
- FILL: req_cnt counts issued reads, rx_cnt counts captured bits, both $clog2(FRAME_WIDTH)+1 bits wide.
- o_R_en = (state==FILL) && !i_Empty && (req_cnt < FRAME_WIDTH) && !i_Clr.
- rd_pend register = o_R_en delayed one cycle. When rd_pend=1, capture i_Data_In into shift register position rx_cnt (LSB_FIRST) or FRAME_WIDTH-1-rx_cnt, and increment rx_cnt.
- Capture making rx_cnt reach FRAME_WIDTH -> PRESENT; o_Frame loaded, o_Valid=1 in the same edge.
- PRESENT: o_R_en=0. Hold o_Frame/o_Valid until o_Valid && i_Ready. On that edge: o_Frame_Cnt+1 (wraps to 0 at all-ones); next state FILL if i_Enable, else IDLE.
- i_Enable deasserted during FILL: current frame completes; takes effect only at the PRESENT handshake.
- i_Empty during FILL: reads pause, no bits captured, no timeout; partial frame held indefinitely.
- i_Clr (priority over all but reset): state->IDLE, counters/rd_pend/o_Valid cleared; o_R_en forced 0 that cycle. Any bit in flight (rd_pend=1) is dropped. o_Frame_Cnt unchanged.
- Reset (async, any time): state IDLE, o_Valid=0, o_Frame=0, o_Busy=0, o_Frame_Cnt=0, rd_pend=0, counters 0, so o_R_en=0. Bits already read before reset are lost.

## Timing
- FIFO read latency is fixed at 1 cycle; the framer never samples i_Data_In except on rd_pend.
- With i_Enable=1 and FIFO never empty: IDLE->FILL at edge 0. o_R_en is high cycles 1..FRAME_WIDTH. Captures occur at the ends of cycles 2..FRAME_WIDTH+1. o_Valid is high from cycle FRAME_WIDTH+2.
- With i_Ready=1, o_Valid lasts exactly 1 cycle. The next frame's reads start the cycle after the handshake. Steady-state period is FRAME_WIDTH+2 cycles per frame.
- Backpressure: while o_Valid && !i_Ready, zero reads are issued and o_Frame does not change.
- o_Busy = (state != IDLE), registered-state decode, glitch-free.

## Test plan
- Reset: hold i_Rrst_n=0 mid-FILL (rx_cnt=3) -> all outputs 0 immediately (asynchronous). After release with i_Enable=0, o_R_en stays 0.
- Streaming: FRAME_WIDTH=8, LSB_FIRST=1, FIFO preloaded with bits 1,0,1,1,0,0,1,0, i_Ready=1 -> o_Frame=8'h4D; o_Valid high exactly in cycle 10 after enable; o_Frame_Cnt=1.
- Empty gaps: i_Empty toggled every other cycle during FILL -> exactly 8 o_R_en pulses per frame, no capture without a preceding o_R_en, correct frame value.
- Backpressure: i_Ready=0 for 5 cycles after o_Valid -> o_Frame stable, o_R_en=0 throughout; accepted on the 6th cycle; o_Frame_Cnt increments once.
- Abort: i_Clr pulsed after 5 captures with rd_pend=1 -> IDLE next cycle, o_Valid=0, o_Frame_Cnt unchanged. The next frame uses only bits read after restart.
- Wrap/ordering: CNT_WIDTH=4, 17 frames with LSB_FIRST=0 -> o_Frame_Cnt=1 after wrap; first bit read appears in o_Frame[7].

Source files
------------

// File: rtl/fifo_rd_framer.sv
// Read-side framer for the 1-bit receive async FIFO: issues FIFO reads, packs
// the serial bits into FRAME_WIDTH-bit frames and hands them off over valid/ready.
module fifo_rd_framer #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter bit          LSB_FIRST   = 1'b1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   i_Rclk,
  input  logic                   i_Rrst_n,
  input  logic                   i_Enable,
  input  logic                   i_Clr,
  input  logic                   i_Empty,
  output logic                   o_R_en,
  input  logic                   i_Data_In,
  output logic [FRAME_WIDTH-1:0] o_Frame,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic                   o_Busy,
  output logic [CNT_WIDTH-1:0]   o_Frame_Cnt
);

  localparam int unsigned     RC_W      = $clog2(FRAME_WIDTH) + 1;
  localparam logic [RC_W-1:0] FRAME_LEN = RC_W'(FRAME_WIDTH);
  localparam logic [RC_W-1:0] LAST_IDX  = RC_W'(FRAME_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [RC_W-1:0]        req_cnt;
  logic [RC_W-1:0]        req_cnt_nxt;
  logic [RC_W-1:0]        rx_cnt;
  logic [RC_W-1:0]        rx_cnt_nxt;
  logic [RC_W-1:0]        bit_idx;
  logic                   rd_pend;
  logic [FRAME_WIDTH-1:0] shreg;
  logic [FRAME_WIDTH-1:0] shreg_nxt;
  logic [FRAME_WIDTH-1:0] frame_q;
  logic [FRAME_WIDTH-1:0] frame_nxt;
  logic                   valid_q;
  logic                   busy_q;
  logic [CNT_WIDTH-1:0]   frame_cnt;
  logic [CNT_WIDTH-1:0]   frame_cnt_nxt;
  logic                   r_en_c;

  // Next-state, read request and bit capture; abort overrides everything.
  always_comb begin
    state_nxt     = state;
    req_cnt_nxt   = req_cnt;
    rx_cnt_nxt    = rx_cnt;
    shreg_nxt     = shreg;
    frame_nxt     = frame_q;
    frame_cnt_nxt = frame_cnt;
    r_en_c        = 1'b0;
    bit_idx       = LSB_FIRST ? rx_cnt : (LAST_IDX - rx_cnt);

    if (i_Clr) begin
      state_nxt   = S_IDLE;
      req_cnt_nxt = '0;
      rx_cnt_nxt  = '0;
      shreg_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_Enable) begin
            state_nxt   = S_FILL;
            req_cnt_nxt = '0;
            rx_cnt_nxt  = '0;
          end
        end
        S_FILL: begin
          r_en_c = !i_Empty && (req_cnt < FRAME_LEN);
          if (r_en_c) begin
            req_cnt_nxt = req_cnt + RC_W'(1);
          end
          // Data returned for last cycle's read lands in its frame slot.
          if (rd_pend) begin
            for (int i = 0; i < int'(FRAME_WIDTH); i++) begin
              if (bit_idx == RC_W'(i)) begin
                shreg_nxt[i] = i_Data_In;
              end
            end
            rx_cnt_nxt = rx_cnt + RC_W'(1);
            if (rx_cnt == LAST_IDX) begin
              frame_nxt = shreg_nxt;
              state_nxt = S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          if (i_Ready) begin
            frame_cnt_nxt = frame_cnt + CNT_WIDTH'(1);
            req_cnt_nxt   = '0;
            rx_cnt_nxt    = '0;
            state_nxt     = i_Enable ? S_FILL : S_IDLE;
          end
        end
        default: begin
          state_nxt   = S_IDLE;
          req_cnt_nxt = '0;
          rx_cnt_nxt  = '0;
        end
      endcase
    end
  end

  // State and datapath registers; valid/busy are decoded from the next state.
  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      state     <= S_IDLE;
      req_cnt   <= '0;
      rx_cnt    <= '0;
      rd_pend   <= 1'b0;
      shreg     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      req_cnt   <= req_cnt_nxt;
      rx_cnt    <= rx_cnt_nxt;
      rd_pend   <= r_en_c;
      shreg     <= shreg_nxt;
      frame_q   <= frame_nxt;
      valid_q   <= (state_nxt == S_PRESENT);
      busy_q    <= (state_nxt != S_IDLE);
      frame_cnt <= frame_cnt_nxt;
    end
  end

  assign o_R_en      = r_en_c;
  assign o_Frame     = frame_q;
  assign o_Valid     = valid_q;
  assign o_Busy      = busy_q;
  assign o_Frame_Cnt = frame_cnt;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Directed bench for fifo_rd_framer: FIFO model, expected-frame scoreboard and
// two instances (LSB-first/16-bit count, MSB-first/4-bit count) sharing stimulus.
module tb_fifo_rd_framer;

  localparam int unsigned FW = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic          empty;
  logic          data_in;
  logic          ready;
  logic          r_en_a;
  logic          valid_a;
  logic          busy_a;
  logic [FW-1:0] frame_a;
  logic [15:0]   cnt_a;
  logic          r_en_b;
  logic          valid_b;
  logic          busy_b;
  logic [FW-1:0] frame_b;
  logic [3:0]    cnt_b;

  int            vectors     = 0;
  int            miscompares = 0;
  int            frames_acc  = 0;
  int            ren_pulses  = 0;
  bit            gap_mode    = 1'b0;
  bit            gap_on      = 1'b0;
  bit            fifo_q[$];
  logic [FW-1:0] exp_q[$];

  fifo_rd_framer #(.FRAME_WIDTH(FW), .LSB_FIRST(1'b1), .CNT_WIDTH(16)) u_lsb (
    .i_Rclk(clk), .i_Rrst_n(rst_n), .i_Enable(en), .i_Clr(clr), .i_Empty(empty),
    .o_R_en(r_en_a), .i_Data_In(data_in), .o_Frame(frame_a), .o_Valid(valid_a),
    .i_Ready(ready), .o_Busy(busy_a), .o_Frame_Cnt(cnt_a)
  );

  fifo_rd_framer #(.FRAME_WIDTH(FW), .LSB_FIRST(1'b0), .CNT_WIDTH(4)) u_msb (
    .i_Rclk(clk), .i_Rrst_n(rst_n), .i_Enable(en), .i_Clr(clr), .i_Empty(empty),
    .o_R_en(r_en_b), .i_Data_In(data_in), .o_Frame(frame_b), .o_Valid(valid_b),
    .i_Ready(ready), .o_Busy(busy_b), .o_Frame_Cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [FW-1:0] rev8(input logic [FW-1:0] v);
    logic [FW-1:0] r;
    for (int i = 0; i < int'(FW); i++) r[i] = v[FW-1-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    empty = (fifo_q.size() == 0) || gap_on;
  endtask

  // Queue a frame's bits (first-read bit = seq[0]); optionally expect it out.
  task automatic push_frame(input logic [FW-1:0] seq, input bit want_exp);
    for (int i = 0; i < int'(FW); i++) fifo_q.push_back(seq[i]);
    if (want_exp) exp_q.push_back(seq);
    update_empty();
  endtask

  // One clock: observe the current cycle, then model the 1-cycle FIFO read latency.
  task automatic tick();
    logic          ren;
    logic [FW-1:0] e;
    #1;
    ren = r_en_a;
    if (ren) begin
      ren_pulses++;
      check("ren_while_empty", 32'(empty), 32'd0);
    end
    if (valid_a && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(valid_a), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_lsb", 32'(frame_a), 32'(e));
        check("frame_msb", 32'(frame_b), 32'(rev8(e)));
        frames_acc++;
      end
    end
    @(posedge clk);
    #1;
    if (ren && fifo_q.size() > 0) data_in = fifo_q.pop_front();
    else data_in = 1'($urandom);
    gap_on = gap_mode ? !gap_on : 1'b0;
    update_empty();
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!valid_a && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(valid_a), 32'd1);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    ready   = 1'b0;
    data_in = 1'b0;
    empty   = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_frame", 32'(frame_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    check("rst_ren", 32'(r_en_a), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Streaming: 1,0,1,1,0,0,1,0 -> 8'h4D, valid only in cycle 10.
    push_frame(8'h4D, 1'b1);
    ready = 1'b1;
    en    = 1'b1;
    #1;
    check("stream_idle_ren", 32'(r_en_a), 32'd0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      check("stream_ren", 32'(r_en_a), 32'(c <= 8));
      check("stream_valid", 32'(valid_a), 32'(c == 10));
      check("stream_busy", 32'(busy_a), 32'd1);
    end
    check("stream_cnt", 32'(cnt_a), 32'd1);

    // Empty gaps: FIFO flag toggles, junk on data_in between reads.
    gap_mode   = 1'b1;
    ren_pulses = 0;
    push_frame(8'hB6, 1'b1);
    wait_valid("gaps_valid_timeout", 40);
    tick();
    check("gaps_ren_pulses", 32'(ren_pulses), 32'd8);
    check("gaps_cnt", 32'(cnt_a), 32'd2);
    gap_mode = 1'b0;
    gap_on   = 1'b0;
    update_empty();

    // Backpressure: 5 stalled cycles with data waiting, accept on the 6th.
    ready = 1'b0;
    push_frame(8'h93, 1'b1);
    wait_valid("bp_valid_timeout", 30);
    push_frame(8'hE5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 32'(valid_a), 32'd1);
      check("bp_frame", 32'(frame_a), 32'(exp_q[0]));
      check("bp_ren", 32'(r_en_a), 32'd0);
      check("bp_cnt_hold", 32'(cnt_a), 32'd2);
      tick();
    end
    ready = 1'b1;
    #1;
    check("bp_valid_6th", 32'(valid_a), 32'd1);
    tick();
    check("bp_cnt", 32'(cnt_a), 32'd3);
    check("bp_valid_drop", 32'(valid_a), 32'd0);

    // Abort with a bit in flight after 5 captures.
    repeat (6) tick();
    check("pre_clr_busy", 32'(busy_a), 32'd1);
    clr = 1'b1;
    #1;
    check("clr_ren", 32'(r_en_a), 32'd0);
    tick();
    clr = 1'b0;
    #1;
    check("clr_busy", 32'(busy_a), 32'd0);
    check("clr_valid", 32'(valid_a), 32'd0);
    check("clr_cnt_a", 32'(cnt_a), 32'd3);
    check("clr_cnt_b", 32'(cnt_b), 32'd3);
    fifo_q.delete();
    push_frame(8'h5A, 1'b1);
    wait_valid("abort_valid_timeout", 30);
    tick();
    check("abort_cnt", 32'(cnt_a), 32'd4);

    // Asynchronous reset mid-frame after three captures.
    push_frame(8'hC3, 1'b0);
    repeat (4) tick();
    #1;
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy_a", 32'(busy_a), 32'd0);
    check("arst_busy_b", 32'(busy_b), 32'd0);
    check("arst_valid", 32'(valid_a), 32'd0);
    check("arst_frame_a", 32'(frame_a), 32'd0);
    check("arst_frame_b", 32'(frame_b), 32'd0);
    check("arst_cnt_a", 32'(cnt_a), 32'd0);
    check("arst_cnt_b", 32'(cnt_b), 32'd0);
    check("arst_ren", 32'(r_en_a), 32'd0);
    frames_acc = 0;
    exp_q.delete();
    fifo_q.delete();
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    push_frame(8'hFF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_ren", 32'(r_en_a), 32'd0);
      check("post_rst_busy", 32'(busy_a), 32'd0);
    end
    fifo_q.delete();
    update_empty();

    // Counter wrap on the 4-bit instance and bit ordering over 17 frames.
    en    = 1'b1;
    ready = 1'b1;
    push_frame(8'h01, 1'b1);
    for (int f = 1; f < 17; f++) push_frame(8'($urandom), 1'b1);
    n = 0;
    while (frames_acc < 17 && n < 400) begin
      tick();
      n++;
    end
    check("wrap_frames", 32'(frames_acc), 32'd17);
    #1;
    check("wrap_cnt_b", 32'(cnt_b), 32'd1);
    check("wrap_cnt_a", 32'(cnt_a), 32'd17);
    en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
